// File: rtl/quantum_preempt_controller.sv
// Time-slice preemption controller: counts retired user instructions against a
// loadable quantum, redirects fetch to SO_VECTOR on expiry. Optional stats: PREEMPT_STATS_EN.
module quantum_preempt_controller #(
    parameter int                    DATA_WIDTH      = 32,
    parameter int                    CNT_WIDTH       = 16,
    parameter logic [CNT_WIDTH-1:0]  DEFAULT_QUANTUM = 16'd20,
    parameter logic [DATA_WIDTH-1:0] SO_VECTOR       = 32'd3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  instr_retire,
    input  logic [DATA_WIDTH-1:0] pc_curr,
    input  logic                  preempt_enable,
    input  logic                  quantum_load,
    input  logic [CNT_WIDTH-1:0]  quantum_in,
    input  logic                  so_done,
`ifdef PREEMPT_STATS_EN
    input  logic                  stats_clr,
    output logic [CNT_WIDTH-1:0]  preempt_total,
`endif
    output logic                  enable_so,
    output logic                  pc_override,
    output logic [DATA_WIDTH-1:0] pc_new,
    output logic [DATA_WIDTH-1:0] saved_pc,
    output logic [CNT_WIDTH-1:0]  quantum_cnt,
    output logic [1:0]            state_o
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_SWITCH = 2'd1,
        ST_OS     = 2'd2
    } state_t;

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [CNT_WIDTH-1:0]    quantum_r;
    logic [CNT_WIDTH-1:0]    cnt_r;
    logic [CNT_WIDTH-1:0]    cnt_nxt_s;
    logic [CNT_WIDTH:0]      cnt_inc_s;
    logic [DATA_WIDTH-1:0]   saved_pc_r;
    logic                    enable_so_r;
    logic                    pc_override_r;
    logic                    count_qual_s;
    logic                    expiry_s;

    // Next-state and counter update; the compare is one bit wider so it never wraps.
    always_comb begin
        state_nxt_s  = state_r;
        cnt_nxt_s    = cnt_r;
        expiry_s     = 1'b0;
        count_qual_s = instr_retire & preempt_enable & (quantum_r != {CNT_WIDTH{1'b0}});
        cnt_inc_s    = {1'b0, cnt_r} + {{CNT_WIDTH{1'b0}}, 1'b1};
        case (state_r)
            ST_RUN: begin
                if (count_qual_s) begin
                    if (cnt_inc_s >= {1'b0, quantum_r}) begin
                        expiry_s    = 1'b1;
                        state_nxt_s = ST_SWITCH;
                        cnt_nxt_s   = {CNT_WIDTH{1'b0}};
                    end else begin
                        cnt_nxt_s   = cnt_inc_s[CNT_WIDTH-1:0];
                    end
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_SWITCH: begin
                state_nxt_s = ST_OS;
                cnt_nxt_s   = {CNT_WIDTH{1'b0}};
            end
            ST_OS: begin
                cnt_nxt_s = {CNT_WIDTH{1'b0}};
                if (so_done) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_OS;
                end
            end
            default: begin
                state_nxt_s = ST_RUN;
                cnt_nxt_s   = {CNT_WIDTH{1'b0}};
            end
        endcase
    end

    // State, counter, quantum, saved PC and mode outputs; outputs track the next state so they are flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_RUN;
            cnt_r         <= {CNT_WIDTH{1'b0}};
            quantum_r     <= DEFAULT_QUANTUM;
            saved_pc_r    <= {DATA_WIDTH{1'b0}};
            enable_so_r   <= 1'b0;
            pc_override_r <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            cnt_r         <= cnt_nxt_s;
            enable_so_r   <= (state_nxt_s != ST_RUN);
            pc_override_r <= (state_nxt_s == ST_SWITCH);
            if (expiry_s) begin
                saved_pc_r <= pc_curr;
            end else begin
                saved_pc_r <= saved_pc_r;
            end
            // Expiry above already used the old quantum; the new one applies next cycle.
            if (quantum_load) begin
                quantum_r <= quantum_in;
            end else begin
                quantum_r <= quantum_r;
            end
        end
    end

`ifdef PREEMPT_STATS_EN
    logic [CNT_WIDTH-1:0] total_r;

    // Saturating preemption counter; a clear coinciding with an expiry leaves 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            total_r <= {CNT_WIDTH{1'b0}};
        end else if (stats_clr) begin
            total_r <= expiry_s ? {{(CNT_WIDTH-1){1'b0}}, 1'b1} : {CNT_WIDTH{1'b0}};
        end else if (expiry_s && (total_r != {CNT_WIDTH{1'b1}})) begin
            total_r <= total_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            total_r <= total_r;
        end
    end

    assign preempt_total = total_r;
`endif

    assign enable_so   = enable_so_r;
    assign pc_override = pc_override_r;
    assign pc_new      = pc_override_r ? SO_VECTOR : pc_curr;
    assign saved_pc    = saved_pc_r;
    assign quantum_cnt = cnt_r;
    assign state_o     = state_r;

endmodule

// File: tb/tb_quantum_preempt_controller.sv
// Randomized + directed bench for quantum_preempt_controller against a cycle-level
// behavioural model; covers the PREEMPT_STATS_EN counter when that macro is defined.
module tb_quantum_preempt_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        instr_retire = 1'b0;
    logic [31:0] pc_curr = 32'd0;
    logic        preempt_enable = 1'b1;
    logic        quantum_load = 1'b0;
    logic [15:0] quantum_in = 16'd0;
    logic        so_done = 1'b0;
    logic        enable_so;
    logic        pc_override;
    logic [31:0] pc_new;
    logic [31:0] saved_pc;
    logic [15:0] quantum_cnt;
    logic [1:0]  state_o;
`ifdef PREEMPT_STATS_EN
    logic        stats_clr = 1'b0;
    logic [15:0] preempt_total;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference model: mode 0=user, 1=redirect cycle, 2=OS
    int          m_mode;
    int          m_cnt;
    int          m_q;
    logic [31:0] m_saved;
    int          m_total;

    quantum_preempt_controller dut (
        .clk            (clk),
        .rst            (rst),
        .instr_retire   (instr_retire),
        .pc_curr        (pc_curr),
        .preempt_enable (preempt_enable),
        .quantum_load   (quantum_load),
        .quantum_in     (quantum_in),
        .so_done        (so_done),
`ifdef PREEMPT_STATS_EN
        .stats_clr      (stats_clr),
        .preempt_total  (preempt_total),
`endif
        .enable_so      (enable_so),
        .pc_override    (pc_override),
        .pc_new         (pc_new),
        .saved_pc       (saved_pc),
        .quantum_cnt    (quantum_cnt),
        .state_o        (state_o)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_edge();
        bit fire;
        fire = 1'b0;
        if (rst) begin
            m_mode = 0; m_cnt = 0; m_q = 20; m_saved = 32'd0; m_total = 0;
        end else begin
            if (m_mode == 0) begin
                if (instr_retire && preempt_enable && m_q != 0) begin
                    if (m_cnt + 1 >= m_q) begin
                        fire = 1'b1; m_mode = 1; m_saved = pc_curr; m_cnt = 0;
                    end else begin
                        m_cnt = m_cnt + 1;
                    end
                end
            end else if (m_mode == 1) begin
                m_mode = 2;
            end else if (so_done) begin
                m_mode = 0;
            end
            if (quantum_load) m_q = int'(quantum_in);
`ifdef PREEMPT_STATS_EN
            if (stats_clr) m_total = fire ? 1 : 0;
            else if (fire && m_total < 65535) m_total = m_total + 1;
`endif
        end
    endtask

    task automatic compare_all();
        check_value("state", 64'(state_o), 64'(m_mode));
        check_value("enable_so", 64'(enable_so), 64'(m_mode != 0));
        check_value("pc_override", 64'(pc_override), 64'(m_mode == 1));
        check_value("pc_new", 64'(pc_new), (m_mode == 1) ? 64'd3 : 64'(pc_curr));
        check_value("saved_pc", 64'(saved_pc), 64'(m_saved));
        check_value("quantum_cnt", 64'(quantum_cnt), 64'(m_cnt));
`ifdef PREEMPT_STATS_EN
        check_value("preempt_total", 64'(preempt_total), 64'(m_total));
`endif
    endtask

    // One clock: model and DUT see the same inputs, then outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic idle_inputs();
        rst = 1'b0; instr_retire = 1'b0; preempt_enable = 1'b1;
        quantum_load = 1'b0; so_done = 1'b0;
`ifdef PREEMPT_STATS_EN
        stats_clr = 1'b0;
`endif
    endtask

    task automatic do_reset();
        idle_inputs(); rst = 1'b1; tick(); rst = 1'b0;
    endtask

    task automatic retires(input int n);
        for (int i = 0; i < n; i++) begin
            instr_retire = 1'b1; pc_curr = $urandom; tick();
        end
        instr_retire = 1'b0;
    endtask

    task automatic finish_os();
        tick();                 // SWITCH -> OS
        so_done = 1'b1; tick(); // OS -> RUN
        so_done = 1'b0;
    endtask

    task automatic load_q(input logic [15:0] q);
        quantum_load = 1'b1; quantum_in = q; tick(); quantum_load = 1'b0;
    endtask

    initial begin
        idle_inputs();
        do_reset();
        check_value("rst_state", 64'(state_o), 64'd0);
        check_value("rst_cnt", 64'(quantum_cnt), 64'd0);

        // Default quantum: 20th retire expires
        retires(19);
        check_value("cnt19", 64'(quantum_cnt), 64'd19);
        instr_retire = 1'b1; pc_curr = 32'h40; tick(); instr_retire = 1'b0;
        check_value("sw_override", 64'(pc_override), 64'd1);
        check_value("sw_pc_new", 64'(pc_new), 64'd3);
        check_value("sw_saved", 64'(saved_pc), 64'h40);
        so_done = 1'b1; tick(); so_done = 1'b0;  // so_done in SWITCH ignored
        check_value("os_enable", 64'(enable_so), 64'd1);
        check_value("os_state", 64'(state_o), 64'd2);
        so_done = 1'b1; tick(); so_done = 1'b0;
        check_value("run_after_os", 64'(state_o), 64'd0);
        check_value("run_cnt0", 64'(quantum_cnt), 64'd0);

        // so_done in RUN is ignored
        so_done = 1'b1; tick(); so_done = 1'b0;
        check_value("so_done_run", 64'(state_o), 64'd0);

        // Load 5 after 3 retires, expiry on 5th
        retires(3); load_q(16'd5); retires(1);
        check_value("q5_not_yet", 64'(state_o), 64'd0);
        retires(1);
        check_value("q5_expire", 64'(state_o), 64'd1);
        finish_os();
        // Load 2 at count 4 -> next retire expires
        retires(4); load_q(16'd2); retires(1);
        check_value("q2_expire", 64'(state_o), 64'd1);
        finish_os();

        // Quantum 0 disables preemption and freezes count
        load_q(16'd20); retires(3); load_q(16'd0); retires(100);
        check_value("q0_state", 64'(state_o), 64'd0);
        check_value("q0_cnt", 64'(quantum_cnt), 64'd3);

        // preempt_enable low holds count
        do_reset(); retires(10);
        preempt_enable = 1'b0; retires(6); preempt_enable = 1'b1;
        check_value("pe_hold", 64'(quantum_cnt), 64'd10);
        retires(9);
        check_value("pe_not_yet", 64'(state_o), 64'd0);
        retires(1);
        check_value("pe_expire", 64'(state_o), 64'd1);

        // Reset while in OS; quantum back to 20 afterwards
        load_q(16'd4);
        check_value("pre_rst_os", 64'(state_o), 64'd2);
        do_reset();
        check_value("rst_os_state", 64'(state_o), 64'd0);
        check_value("rst_os_en", 64'(enable_so), 64'd0);
        check_value("rst_os_saved", 64'(saved_pc), 64'd0);
        retires(19);
        check_value("rst_q20", 64'(state_o), 64'd0);
        retires(1);
        check_value("rst_q20_exp", 64'(state_o), 64'd1);
        finish_os();

`ifdef PREEMPT_STATS_EN
        do_reset(); load_q(16'd2);
        for (int k = 0; k < 3; k++) begin
            retires(2); finish_os();
        end
        check_value("stats3", 64'(preempt_total), 64'd3);
        retires(1);
        stats_clr = 1'b1; instr_retire = 1'b1; tick();
        stats_clr = 1'b0; instr_retire = 1'b0;
        check_value("stats_clr_inc", 64'(preempt_total), 64'd1);
        finish_os();
`endif

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            rst            = ($urandom_range(0, 199) == 0);
            instr_retire   = ($urandom_range(0, 9) < 7);
            preempt_enable = ($urandom_range(0, 9) < 9);
            quantum_load   = ($urandom_range(0, 19) == 0);
            quantum_in     = ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom_range(1, 7));
            so_done        = ($urandom_range(0, 2) == 0);
            pc_curr        = $urandom;
`ifdef PREEMPT_STATS_EN
            stats_clr      = ($urandom_range(0, 49) == 0);
`endif
            tick();
        end
        idle_inputs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/quantum_preempt_controller.md
Name: quantum_preempt_controller

Overview:
- Parametrised time-slice preemption controller for the core's PC path.
- Counts retired user-mode instructions against a runtime-loadable quantum. On expiry it saves the interrupted PC, redirects fetch to the OS context-switch vector for one cycle, and holds OS mode until the OS signals completion.
- Sits between the PC register and the fetch mux; drives enable_so to the mode/privilege logic.

Parameters:
- DATA_WIDTH, 32: PC width.
- CNT_WIDTH, 16: width of the instruction counter and of the quantum.
- DEFAULT_QUANTUM, 20: quantum value loaded at reset.
- SO_VECTOR, 3: PC of the OS context-switch routine, DATA_WIDTH wide.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- instr_retire  in  1  one user instruction retired this cycle.
- pc_curr  in  DATA_WIDTH  address of the next instruction to fetch.
- preempt_enable  in  1  1 = counting allowed; 0 = counter frozen.
- quantum_load  in  1  load quantum_in into the quantum register.
- quantum_in  in  CNT_WIDTH  new quantum; 0 disables preemption.
- so_done  in  1  OS has finished the context switch; resume user mode.
- enable_so  out  1  core is in OS mode (SWITCH or OS state).
- pc_override  out  1  fetch must take pc_new this cycle.
- pc_new  out  DATA_WIDTH  SO_VECTOR in SWITCH, else pc_curr (combinational).
- saved_pc  out  DATA_WIDTH  pc_curr captured at expiry.
- quantum_cnt  out  CNT_WIDTH  current instruction count.
- state_o  out  2  encoded state: RUN=0, SWITCH=1, OS=2.

Behaviour:
- One clock domain. Reset is synchronous, active-high, named rst; clock named clk.
- Reset values:
  - state = RUN; quantum_cnt = 0; saved_pc = 0.
  - quantum register = DEFAULT_QUANTUM.
  - enable_so = 0; pc_override = 0; pc_new = pc_curr.
- RUN:
  - If instr_retire & preempt_enable & quantum != 0:
    - If quantum_cnt + 1 >= quantum, this is expiry: next state = SWITCH, saved_pc <= pc_curr, quantum_cnt <= 0.
    - Otherwise quantum_cnt <= quantum_cnt + 1.
  - Comparison is done at CNT_WIDTH+1 bits; no wrap.
- SWITCH:
  - Lasts exactly 1 cycle.
  - enable_so = 1, pc_override = 1, pc_new = SO_VECTOR.
  - Next state = OS unconditionally.
- OS:
  - enable_so = 1, pc_override = 0, pc_new = pc_curr.
  - Counter frozen at 0; instr_retire is ignored.
  - so_done = 1: next state = RUN, counter stays 0, enable_so drops on the following cycle.
- Latency: expiry retire at cycle N gives SWITCH (redirect) at N+1 and OS from N+2.
- quantum_load:
  - Accepted in any state; the new value is used from the next cycle.
  - Expiry and load in the same cycle: expiry uses the old quantum, the register takes the new value.
  - New quantum <= current count in RUN: expiry fires on the next qualifying retire.
- quantum = 0: no counting and no expiry; the counter holds its value.
- preempt_enable = 0 in RUN: the counter holds and no expiry occurs. It does not affect SWITCH or OS.
- so_done in RUN or SWITCH: ignored.
- rst mid-SWITCH or mid-OS: returns to RUN immediately. saved_pc is cleared and the quantum register is reloaded to DEFAULT_QUANTUM.

Optional Feature:
- Macro PREEMPT_STATS_EN.
- Defined:
  - Adds output preempt_total [CNT_WIDTH], reset 0.
  - Increments on every SWITCH entry and saturates at all-ones.
  - Adds input stats_clr (1 bit), which clears the count synchronously. If a clear and an increment occur in the same cycle, the result is 1.
- Undefined: preempt_total and stats_clr do not exist, and there is no counter logic.

Test Plan:
- Reset, then 20 consecutive retires with pc_curr=0x40 at the 20th -> SWITCH on the next cycle, pc_new=0x3, pc_override=1, saved_pc=0x40. OS follows with enable_so=1; so_done -> RUN, quantum_cnt=0.
- quantum_load=5 after 3 retires, then 2 more retires -> expiry on the 5th retire. Separately, quantum_load=2 when count=4 -> expiry on the next retire.
- quantum_in=0, then 100 retires -> state stays RUN, no pc_override, quantum_cnt unchanged.
- preempt_enable=0 during retires 10-15 -> count holds at 10. Resume -> expiry after 10 further retires.
- so_done asserted in RUN and in SWITCH -> no effect. rst asserted in OS -> RUN, enable_so=0, quantum=20, saved_pc=0 the next cycle.
- PREEMPT_STATS_EN: 3 full preempt cycles -> preempt_total=3. stats_clr together with a SWITCH entry -> preempt_total=1.
